// File: rtl/wb_arbiter_if.sv
// Write-port bundle between two writeback requesters (A = ALU, B = load)
// and the register file, with the arbiter sitting in between.
interface wb_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          A_VALID;
    logic          A_READY;
    logic [AW-1:0] A_RW;
    logic [DW-1:0] A_DIN;

    logic          B_VALID;
    logic          B_READY;
    logic [AW-1:0] B_RW;
    logic [DW-1:0] B_DIN;

    logic          WE;
    logic [AW-1:0] RW;
    logic [DW-1:0] Din;

    logic          PEND_A;
    logic          PEND_B;

    // Arbiter side: accepts requests, drives the register-file write port.
    modport slave (
        input  A_VALID, A_RW, A_DIN,
        input  B_VALID, B_RW, B_DIN,
        output A_READY, B_READY,
        output WE, RW, Din,
        output PEND_A, PEND_B
    );

    // Requester / register-file side.
    modport master (
        output A_VALID, A_RW, A_DIN,
        output B_VALID, B_RW, B_DIN,
        input  A_READY, B_READY,
        input  WE, RW, Din,
        input  PEND_A, PEND_B
    );
endinterface

// File: rtl/wb_arbiter.sv
// Two-requester writeback arbiter in front of a single register-file write
// port. Each requester owns one holding entry; pending entries are granted
// combinationally and drained into a registered write port one per cycle.
//
// Round-robin pointer (last granted requester):
//   state  | meaning
//   SRC_A  | A granted last, B wins the next tie
//   SRC_B  | B granted last (reset value), A wins the next tie
module wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          CLK,
    input  logic          RST,
    wb_arbiter_if.slave   bus
);

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    src_t          last_grant;

    logic          pend_a;
    logic [AW-1:0] rw_a;
    logic [DW-1:0] din_a;

    logic          pend_b;
    logic [AW-1:0] rw_b;
    logic [DW-1:0] din_b;

    logic          grant_a;
    logic          grant_b;
    logic          ready_a;
    logic          ready_b;
    logic          accept_a;
    logic          accept_b;

    logic          we_q;
    logic [AW-1:0] rw_q;
    logic [DW-1:0] din_q;

    // Grant selection: a lone pending entry always wins, a tie goes to the
    // requester that was not granted last.
    always_comb begin
        grant_a = pend_a & (~pend_b | (last_grant == SRC_B));
        grant_b = pend_b & (~pend_a | (last_grant == SRC_A));
    end

    // An entry can take new data when empty or when it drains on this same
    // edge; nothing is accepted while reset is asserted.
    always_comb begin
        ready_a  = ~RST & (~pend_a | grant_a);
        ready_b  = ~RST & (~pend_b | grant_b);
        accept_a = bus.A_VALID & ready_a;
        accept_b = bus.B_VALID & ready_b;
    end

    // Holding entry A: capture on acceptance, otherwise clear when granted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_a <= 1'b0;
            rw_a   <= '0;
            din_a  <= '0;
        end else if (accept_a) begin
            pend_a <= 1'b1;
            rw_a   <= bus.A_RW;
            din_a  <= bus.A_DIN;
        end else if (grant_a) begin
            pend_a <= 1'b0;
        end
    end

    // Holding entry B: capture on acceptance, otherwise clear when granted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_b <= 1'b0;
            rw_b   <= '0;
            din_b  <= '0;
        end else if (accept_b) begin
            pend_b <= 1'b1;
            rw_b   <= bus.B_RW;
            din_b  <= bus.B_DIN;
        end else if (grant_b) begin
            pend_b <= 1'b0;
        end
    end

    // Write port and round-robin pointer; register 0 is consumed silently.
    always_ff @(posedge CLK) begin
        if (RST) begin
            we_q       <= 1'b0;
            rw_q       <= '0;
            din_q      <= '0;
            last_grant <= SRC_B;
        end else if (grant_a) begin
            we_q       <= (rw_a != '0);
            rw_q       <= rw_a;
            din_q      <= din_a;
            last_grant <= SRC_A;
        end else if (grant_b) begin
            we_q       <= (rw_b != '0);
            rw_q       <= rw_b;
            din_q      <= din_b;
            last_grant <= SRC_B;
        end else begin
            we_q       <= 1'b0;
        end
    end

    assign bus.A_READY = ready_a;
    assign bus.B_READY = ready_b;
    assign bus.WE      = we_q;
    assign bus.RW      = rw_q;
    assign bus.Din     = din_q;
    assign bus.PEND_A  = pend_a;
    assign bus.PEND_B  = pend_b;

endmodule
